// File: rtl/hvsync_decoder_pkg.sv
// Shared video timing constants and types for the sync generator and decoder.
// Horizontal sync geometry sets the hpos reload value; the vsync line sets the vpos reload value.
package hvsync_decoder_pkg;

   localparam int DEF_H_DISPLAY  = 256;
   localparam int DEF_H_TOTAL    = 300;
   localparam int DEF_V_DISPLAY  = 240;
   localparam int DEF_V_TOTAL    = 262;

   localparam int H_SYNC_START   = 281;
   localparam int H_SYNC_WIDTH   = 16;
   localparam int V_SYNC_LINE    = 256;
   localparam int V_SYNC_LINES   = 3;

   // The generator drops hsync during its hpos=H_SYNC_START cycle, so the
   // receiver must present the following position after the edge.
   localparam int DEF_H_SYNC_HPOS = H_SYNC_START + 1;
   localparam int DEF_V_SYNC_VPOS = V_SYNC_LINE;

   localparam int DEF_LOCK_LINES = 4;
   localparam int DEF_H_TIMEOUT  = 600;

   localparam int POS_W    = 9;
   localparam int PERIOD_W = 10;

   typedef logic [POS_W-1:0]    pos_t;
   typedef logic [PERIOD_W-1:0] period_t;

   typedef struct packed {
      pos_t    hpos;
      pos_t    vpos;
      logic    display_on;
      logic    locked;
      period_t line_period;
      logic    frame_start;
   } vid_state_t;

   function automatic period_t period_sat_inc(input period_t v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/hvsync_decoder_if.sv
// Sync wires into the decoder and recovered timing out of it.
// master drives the sync pair; slave is the decoder.
interface hvsync_decoder_if;
   import hvsync_decoder_pkg::*;

   logic    hsync;
   logic    vsync;
   pos_t    hpos;
   pos_t    vpos;
   logic    display_on;
   logic    locked;
   period_t line_period;
   logic    frame_start;

   modport master (
      output hsync, vsync,
      input  hpos, vpos, display_on, locked, line_period, frame_start
   );

   modport slave (
      input  hsync, vsync,
      output hpos, vpos, display_on, locked, line_period, frame_start
   );

endinterface

// File: rtl/hvsync_decoder_sync_edge_detect.sv
// Falling-edge detector on an active-low sync: zero latency, fall uses the current input.
// No backpressure; a level held low across reset release is not an edge.
module sync_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic sync,
   output logic fall
);

   logic sync_d;
   logic armed;

   // armed captures whether the line was high at reset release, so a line
   // still low from before reset must rise first before it can fall.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_d <= 1'b1;
         armed  <= sync;
      end else begin
         sync_d <= sync;
         armed  <= armed | sync;
      end
   end

   assign fall = armed & sync_d & ~sync;

endmodule

// File: rtl/hvsync_decoder.sv
// Rebuilds hpos/vpos/display_on from active-low hsync/vsync, measures line period, reports lock.
// All outputs registered one cycle after the inputs; no backpressure, one sample per clk.
module hvsync_decoder
   import hvsync_decoder_pkg::*;
#(
   parameter int H_DISPLAY   = DEF_H_DISPLAY,
   parameter int H_TOTAL     = DEF_H_TOTAL,
   parameter int V_DISPLAY   = DEF_V_DISPLAY,
   parameter int V_TOTAL     = DEF_V_TOTAL,
   parameter int H_SYNC_HPOS = DEF_H_SYNC_HPOS,
   parameter int V_SYNC_VPOS = DEF_V_SYNC_VPOS,
   parameter int LOCK_LINES  = DEF_LOCK_LINES,
   parameter int H_TIMEOUT   = DEF_H_TIMEOUT
) (
   input  logic             clk,
   input  logic             reset,
   hvsync_decoder_if.slave  vid
);

   localparam int LOCK_W = $clog2(LOCK_LINES + 1);

   logic              hfall;
   logic              vfall;
   pos_t              hpos;
   pos_t              vpos;
   logic              display_on;
   logic              locked;
   logic              frame_start;
   period_t           line_period;
   period_t           cnt;
   logic [LOCK_W-1:0] lock_cnt;
   logic [LOCK_W-1:0] lock_cnt_nxt;
   logic              v_ok;
   logic              v_ok_nxt;
   logic              h_end;
   logic              h_wrap;
   logic              v_end;
   logic              h_on_time;
   logic              v_on_time;
   logic              timeout;

   sync_edge_detect u_hs_edge (
      .clk   (clk),
      .reset (reset),
      .sync  (vid.hsync),
      .fall  (hfall)
   );

   sync_edge_detect u_vs_edge (
      .clk   (clk),
      .reset (reset),
      .sync  (vid.vsync),
      .fall  (vfall)
   );

   assign h_end     = (hpos == pos_t'(H_TOTAL - 1));
   assign h_wrap    = h_end && !hfall;
   assign v_end     = (vpos == pos_t'(V_TOTAL - 1));
   assign h_on_time = (hpos == pos_t'(H_SYNC_HPOS - 1));
   assign v_on_time = (vpos == pos_t'(V_SYNC_VPOS));
   assign timeout   = !hfall && (cnt == period_t'(H_TIMEOUT));

   always_comb begin
      lock_cnt_nxt = lock_cnt;
      v_ok_nxt     = v_ok;
      if (hfall) begin
         if (!h_on_time) begin
            lock_cnt_nxt = '0;
         end else if (lock_cnt != LOCK_W'(LOCK_LINES)) begin
            lock_cnt_nxt = lock_cnt + 1'b1;
         end
      end
      if (vfall) begin
         v_ok_nxt = v_on_time;
      end
      // A missing hsync also invalidates the frame alignment.
      if (timeout) begin
         lock_cnt_nxt = '0;
         v_ok_nxt     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hpos        <= '0;
         vpos        <= '0;
         display_on  <= 1'b0;
         frame_start <= 1'b0;
         line_period <= '0;
         cnt         <= '0;
         lock_cnt    <= '0;
         v_ok        <= 1'b0;
         locked      <= 1'b0;
      end else begin
         if (hfall) begin
            hpos <= pos_t'(H_SYNC_HPOS);
         end else if (h_end) begin
            hpos <= '0;
         end else begin
            hpos <= hpos + 1'b1;
         end

         if (vfall) begin
            vpos <= pos_t'(V_SYNC_VPOS);
         end else if (h_wrap) begin
            vpos <= v_end ? '0 : vpos + 1'b1;
         end

         display_on  <= (hpos < pos_t'(H_DISPLAY)) && (vpos < pos_t'(V_DISPLAY));
         frame_start <= h_wrap && v_end && !vfall;

         if (hfall) begin
            line_period <= cnt;
            cnt         <= period_t'(1);
         end else begin
            cnt <= period_sat_inc(cnt);
         end

         lock_cnt <= lock_cnt_nxt;
         v_ok     <= v_ok_nxt;
         locked   <= (lock_cnt_nxt == LOCK_W'(LOCK_LINES)) && v_ok_nxt;
      end
   end

   assign vid.hpos        = hpos;
   assign vid.vpos        = vpos;
   assign vid.display_on  = display_on;
   assign vid.locked      = locked;
   assign vid.line_period = line_period;
   assign vid.frame_start = frame_start;

endmodule

// File: doc/hvsync_decoder.md
Name: hvsync_decoder

Overview:
- Receiver side of the video sync interface. Takes active-low hsync/vsync, as the sync generator drives them, and rebuilds hpos, vpos and display_on, aligned cycle-for-cycle with the generator.
- Measures the line period and reports lock.
- Used by capture, overlay and genlock logic that only sees the sync wires.

Parameters:
- H_DISPLAY, 256, visible pixels per line
- H_TOTAL, 300, clocks per line; hpos wraps from H_TOTAL-1 to 0
- V_DISPLAY, 240, visible lines per frame
- V_TOTAL, 262, lines per frame; vpos wraps from V_TOTAL-1 to 0
- H_SYNC_HPOS, 282, value loaded into hpos on an hsync falling edge
- V_SYNC_VPOS, 256, value loaded into vpos on a vsync falling edge
- LOCK_LINES, 4, consecutive on-time hsync edges needed for lock
- H_TIMEOUT, 600, clocks without an hsync edge before lock drops; must be < 1023

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- hpos  out  9  recovered horizontal position
- vpos  out  9  recovered vertical position
- display_on  out  1  registered visible-area flag
- locked  out  1  timing locked
- line_period  out  10  clocks between the last two hsync falling edges
- frame_start  out  1  one-cycle pulse at the start of a frame

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All state is registered on posedge clk.
- Reset values:
  - hpos=0, vpos=0, display_on=0, locked=0, line_period=0, frame_start=0.
  - Internal: hs_d=1, vs_d=1, lock_cnt=0, v_ok=0, cnt=0.
  - Reset wins over every other event in the same cycle.
- Edge detect:
  - hfall = hs_d & ~hsync; vfall = vs_d & ~vsync. The current inputs are used, so detection has no extra latency.
  - hs_d/vs_d are loaded from the inputs every cycle.
  - An input held low through the release of reset produces no edge.
- hpos:
  - On hfall: hpos <= H_SYNC_HPOS.
  - Otherwise at H_TOTAL-1: hpos <= 0. Otherwise hpos+1.
  - With a directly connected generator (hsync falls in its hpos=281 cycle), decoder hpos equals generator hpos from the cycle after the first edge.
- vpos:
  - On vfall: vpos <= V_SYNC_VPOS. This overrides the wrap increment in the same cycle.
  - Otherwise, when hpos wraps to 0: vpos <= (vpos==V_TOTAL-1) ? 0 : vpos+1.
  - vfall does not alter hpos.
- display_on <= (hpos<H_DISPLAY) && (vpos<V_DISPLAY), computed from current values. This gives one cycle of lag, matching the generator.
- frame_start <= 1 for exactly one cycle in the cycle where hpos and vpos both become 0 by wrap; otherwise 0. A vfall reload never produces frame_start.
- Period counter cnt (10 bits):
  - On hfall: line_period <= cnt, then cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at 1023.
  - The first edge after reset reports the clocks elapsed since reset.
- Lock logic:
  - An hfall is on-time if hpos == H_SYNC_HPOS-1 at the edge.
  - On-time edge: lock_cnt increments, saturating at LOCK_LINES. Off-time edge: lock_cnt <= 0.
  - A vfall is on-time if vpos == V_SYNC_VPOS. On-time sets v_ok; off-time clears v_ok.
  - When cnt reaches H_TIMEOUT (missing hsync): lock_cnt <= 0 and v_ok <= 0.
  - locked <= (next lock_cnt == LOCK_LINES) && next v_ok. Registered, so it drops in the cycle after the offending edge or timeout.
- Free-running: hpos/vpos keep counting while unlocked or while sync is absent.

Decomposition:
- Shared timing header, video_timing.vh, included by both the generator and this block, holding:
  - H_DISPLAY, H_TOTAL, V_DISPLAY, V_TOTAL
  - hsync start/width and vsync line
  - the derived H_SYNC_HPOS and V_SYNC_VPOS
- One natural sub-module: sync_edge_detect (registered falling-edge detector, reset to 1), instantiated twice.

Test Plan:
- Generator wired to decoder, common reset:
  - After the first vsync edge plus 4 further lines, locked=1.
  - hpos, vpos and display_on equal the generator's every cycle thereafter.
  - line_period=300.
- Reset, then one hsync falling edge: hpos=282 the next cycle, 299 17 cycles later, then 0; vpos increments at that wrap.
- Locked; one hsync edge delayed 3 cycles:
  - Cycle after the edge: locked=0 and hpos=282.
  - line_period=303, then 297 for the following line.
  - locked=1 again after 4 clean lines.
- Locked; hsync held high: locked=0 exactly one cycle after cnt reaches 600; hpos keeps wrapping 299->0.
- Reset asserted mid-frame with hsync=0 held through release:
  - All outputs zero.
  - No hpos reload until hsync rises and falls again.
- Free-run from reset with no sync:
  - frame_start single-cycle pulse when hpos=0 and vpos=0 after vpos passes 261.
  - vfall at vpos=100 loads vpos=256 with no frame_start pulse.
